phy_rx_sync_ctrl: RTL and testbench

Byte-rate receive synchronisation controller for the PHY. It sits between the serial-to-parallel receiver and the link layer. It hunts for comma symbols (8'hBC) and commands bit-slip of the deserializer phase until alignment is found. It then declares the link active after consecutive commas, forwards non-comma bytes as valid data, and drops sync when commas stop arriving.

---
 rtl/phy_rx_sync_ctrl_pkg.sv | 22 ++
 rtl/phy_rx_sync_ctrl_if.sv | 33 +++
 rtl/phy_rx_sync_ctrl_ctr.sv | 38 +++
 rtl/phy_rx_sync_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_phy_rx_sync_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/phy_rx_sync_ctrl_pkg.sv
// Shared definitions for the PHY receive synchronisation controller.
// Holds the comma symbol, the state encoding, the debug state width and a
// counter-width helper.
package phy_rx_sync_ctrl_pkg;

  localparam logic [7:0]  COMMA   = 8'hBC;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned SLIP_W  = 3;

  // Encoding 3 is illegal; the FSM recovers from it to HUNT.
  typedef enum logic [STATE_W-1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    SYNC    = 2'd2
  } state_e;

  // Width needed to hold 0..n, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/phy_rx_sync_ctrl_if.sv
// Byte bus between deserializer/link layer and the sync controller.
// master : byte source and output consumer (deserializer + link layer side)
// slave  : the sync controller
//   byte_in/byte_stb        : incoming byte and its strobe
//   data_out/valid_out      : forwarded data byte and one-cycle qualifier
//   active                  : link in SYNC
//   bit_slip/slip_cnt       : slip command pulse and wrapping slip count
//   sync_lost               : pulse on SYNC->HUNT
//   state_o                 : debug view of FSM state
interface phy_rx_sync_ctrl_if;
  import phy_rx_sync_ctrl_pkg::*;

  logic [7:0]         byte_in;
  logic               byte_stb;
  logic [7:0]         data_out;
  logic               valid_out;
  logic               active;
  logic               bit_slip;
  logic [SLIP_W-1:0]  slip_cnt;
  logic               sync_lost;
  logic [STATE_W-1:0] state_o;

  modport master (
    output byte_in, byte_stb,
    input  data_out, valid_out, active, bit_slip, slip_cnt, sync_lost, state_o
  );

  modport slave (
    input  byte_in, byte_stb,
    output data_out, valid_out, active, bit_slip, slip_cnt, sync_lost, state_o
  );

endinterface

// File: rtl/phy_rx_sync_ctrl_ctr.sv
// phy_ctr: saturating counter with clear, load, increment and decrement.
// Ports: clk, rst_n (async, active-low), clr, load/load_val, inc, dec,
//        tc (count equals the TC parameter).
// Priority: clr > load > inc > dec.
module phy_ctr #(
  parameter int unsigned W  = 4,
  parameter int unsigned TC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Count register; saturates at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == W'(TC));

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Receive synchronisation controller: hunts for commas, commands bit slips,
// confirms N_SYNC consecutive commas, then forwards non-comma bytes until
// MAX_GAP bytes pass without a comma.
// Ports: clk_4f (byte clock), reset_L (async, active-low), en (0 holds HUNT),
//        rx (slave side of phy_rx_sync_ctrl_if; all outputs registered).
module phy_rx_sync_ctrl
  import phy_rx_sync_ctrl_pkg::*;
#(
  parameter int unsigned N_SYNC      = 4,
  parameter int unsigned SLIP_WINDOW = 16,
  parameter int unsigned BLANK       = 2,
  parameter int unsigned MAX_GAP     = 64
) (
  input  logic               clk_4f,
  input  logic               reset_L,
  input  logic               en,
  phy_rx_sync_ctrl_if.slave  rx
);

  localparam int unsigned WIN_W = cnt_w(SLIP_WINDOW);
  localparam int unsigned BC_W  = cnt_w(N_SYNC);
  localparam int unsigned GAP_W = cnt_w(MAX_GAP);
  localparam int unsigned BLK_W = cnt_w(BLANK);

  state_e            state_q, state_nxt;
  logic [7:0]        data_q, data_nxt;
  logic              valid_q, valid_nxt;
  logic              slip_q, slip_nxt;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_nxt;
  logic              lost_q, lost_nxt;
  logic              active_q, active_nxt;

  logic win_clr, win_inc, win_tc;
  logic bc_clr, bc_inc, bc_tc;
  logic gap_clr, gap_inc, gap_tc;
  logic blk_clr, blk_load, blk_dec, blk_zero;

  logic stb, comma;
  assign stb   = rx.byte_stb;
  assign comma = (rx.byte_in == COMMA);

  // Terminal counts fire one below the limit so the decision is taken on the
  // strobe that would bring the count to the limit.
  phy_ctr #(.W(WIN_W), .TC(SLIP_WINDOW - 1)) u_win (
    .clk(clk_4f), .rst_n(reset_L), .clr(win_clr), .load(1'b0),
    .load_val('0), .inc(win_inc), .dec(1'b0), .tc(win_tc)
  );

  phy_ctr #(.W(BC_W), .TC(N_SYNC - 1)) u_bc (
    .clk(clk_4f), .rst_n(reset_L), .clr(bc_clr), .load(1'b0),
    .load_val('0), .inc(bc_inc), .dec(1'b0), .tc(bc_tc)
  );

  phy_ctr #(.W(GAP_W), .TC(MAX_GAP - 1)) u_gap (
    .clk(clk_4f), .rst_n(reset_L), .clr(gap_clr), .load(1'b0),
    .load_val('0), .inc(gap_inc), .dec(1'b0), .tc(gap_tc)
  );

  // Blank counter loads BLANK on a slip and counts down; tc means idle.
  phy_ctr #(.W(BLK_W), .TC(0)) u_blk (
    .clk(clk_4f), .rst_n(reset_L), .clr(blk_clr), .load(blk_load),
    .load_val(BLK_W'(BLANK)), .inc(1'b0), .dec(blk_dec), .tc(blk_zero)
  );

  // Next-state, counter control and output decode.
  always_comb begin
    state_nxt    = state_q;
    data_nxt     = data_q;
    valid_nxt    = 1'b0;
    slip_nxt     = 1'b0;
    slip_cnt_nxt = slip_cnt_q;
    lost_nxt     = 1'b0;
    win_clr      = 1'b0;
    win_inc      = 1'b0;
    bc_clr       = 1'b0;
    bc_inc       = 1'b0;
    gap_clr      = 1'b0;
    gap_inc      = 1'b0;
    blk_clr      = 1'b0;
    blk_load     = 1'b0;
    blk_dec      = 1'b0;

    if (!en) begin
      state_nxt = HUNT;
      lost_nxt  = (state_q == SYNC);
      win_clr   = 1'b1;
      bc_clr    = 1'b1;
      gap_clr   = 1'b1;
      blk_clr   = 1'b1;
    end else begin
      case (state_q)
        HUNT: begin
          if (stb) begin
            if (!blk_zero) begin
              blk_dec = 1'b1;
            end else if (comma) begin
              win_clr   = 1'b1;
              bc_inc    = 1'b1;
              state_nxt = (N_SYNC == 1) ? SYNC : CONFIRM;
            end else if (win_tc) begin
              win_clr      = 1'b1;
              slip_nxt     = 1'b1;
              slip_cnt_nxt = slip_cnt_q + SLIP_W'(1);
              blk_load     = 1'b1;
            end else begin
              win_inc = 1'b1;
            end
          end
        end
        CONFIRM: begin
          if (stb) begin
            if (comma) begin
              bc_inc = 1'b1;
              if (bc_tc) state_nxt = SYNC;
            end else begin
              state_nxt = HUNT;
              bc_clr    = 1'b1;
              win_clr   = 1'b1;
            end
          end
        end
        SYNC: begin
          if (stb) begin
            if (comma) begin
              gap_clr = 1'b1;
            end else if (gap_tc) begin
              state_nxt = HUNT;
              lost_nxt  = 1'b1;
              win_clr   = 1'b1;
              bc_clr    = 1'b1;
              gap_clr   = 1'b1;
              blk_clr   = 1'b1;
            end else begin
              gap_inc   = 1'b1;
              valid_nxt = 1'b1;
              data_nxt  = rx.byte_in;
            end
          end
        end
        default: begin
          state_nxt = HUNT;
          win_clr   = 1'b1;
          bc_clr    = 1'b1;
          gap_clr   = 1'b1;
          blk_clr   = 1'b1;
        end
      endcase
    end

    active_nxt = (state_nxt == SYNC);
  end

  // State and output registers.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= HUNT;
      data_q     <= '0;
      valid_q    <= 1'b0;
      slip_q     <= 1'b0;
      slip_cnt_q <= '0;
      lost_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      data_q     <= data_nxt;
      valid_q    <= valid_nxt;
      slip_q     <= slip_nxt;
      slip_cnt_q <= slip_cnt_nxt;
      lost_q     <= lost_nxt;
      active_q   <= active_nxt;
    end
  end

  assign rx.data_out  = data_q;
  assign rx.valid_out = valid_q;
  assign rx.bit_slip  = slip_q;
  assign rx.slip_cnt  = slip_cnt_q;
  assign rx.sync_lost = lost_q;
  assign rx.active    = active_q;
  assign rx.state_o   = state_q;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Testbench for phy_rx_sync_ctrl: directed byte sequences, expected output
// pulses queued at stimulus time and matched by a monitor on falling edges.
module tb_phy_rx_sync_ctrl;

  localparam int K_DATA = 0;
  localparam int K_SLIP = 1;
  localparam int K_LOST = 2;
  localparam logic [7:0] BC = 8'hBC;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic clk_4f;
  logic reset_L;
  logic en;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  phy_rx_sync_ctrl_if rx ();

  phy_rx_sync_ctrl dut (
    .clk_4f (clk_4f),
    .reset_L(reset_L),
    .en     (en),
    .rx     (rx)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // One strobed byte followed by one idle cycle; returns on the falling edge
  // after the capturing edge, when its registered response is visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk_4f);
    rx.byte_in  = b;
    rx.byte_stb = 1'b1;
    @(negedge clk_4f);
    rx.byte_stb = 1'b0;
  endtask

  task automatic chk_st(input string name, input int st, input logic act);
    chk({name, "_state"}, 32'(rx.state_o), 32'(st));
    chk({name, "_active"}, 32'(rx.active), 32'(act));
  endtask

  task automatic pop_cmp(input int kind, input logic [7:0] data);
    exp_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind %0d data %0h expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.data == data) n_pass++;
      else $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h",
                    kind, data, e.kind, e.data);
    end
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk_4f) begin
    if (reset_L) begin
      if (rx.valid_out) pop_cmp(K_DATA, rx.data_out);
      if (rx.bit_slip)  pop_cmp(K_SLIP, 8'h00);
      if (rx.sync_lost) pop_cmp(K_LOST, 8'h00);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_pass      = 0;
    n_total     = 0;
    rx.byte_in  = 8'h00;
    rx.byte_stb = 1'b0;
    en          = 1'b1;
    reset_L     = 1'b0;
    repeat (3) @(negedge clk_4f);
    reset_L = 1'b1;
    @(negedge clk_4f);

    chk_st("reset", 0, 1'b0);
    chk("reset_slip_cnt", 32'(rx.slip_cnt), 0);
    chk("reset_valid", 32'(rx.valid_out), 0);
    chk("reset_bit_slip", 32'(rx.bit_slip), 0);
    chk("reset_sync_lost", 32'(rx.sync_lost), 0);
    chk("reset_data", 32'(rx.data_out), 0);

    // Acquire: CONFIRM after first comma, SYNC after the fourth.
    for (int i = 1; i <= 5; i++) begin
      send(BC);
      chk_st($sformatf("acq%0d", i), (i >= 4) ? 2 : 1, (i >= 4));
    end

    // Forwarding in SYNC.
    send(BC);
    push(K_DATA, 8'h11); send(8'h11);
    push(K_DATA, 8'h22); send(8'h22);
    chk_st("fwd", 2, 1'b1);

    // Gap loss: 63 bytes forwarded, 64th drops sync.
    send(BC);
    for (int i = 1; i <= 64; i++) begin
      if (i < 64) push(K_DATA, 8'(i));
      else        push(K_LOST, 8'h00);
      send(8'(i));
    end
    chk_st("gap_loss", 0, 1'b0);

    // Slip after 16 non-comma bytes, then two blanked bytes.
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) push(K_SLIP, 8'h00);
      send(8'h00);
    end
    chk("slip_cnt1", 32'(rx.slip_cnt), 1);
    chk_st("slip", 0, 1'b0);
    send(BC); chk_st("blank1", 0, 1'b0);
    send(BC); chk_st("blank2", 0, 1'b0);
    send(BC); chk_st("post_blank", 1, 1'b0);

    // Confirm failure after three commas.
    send(BC);
    send(BC);
    chk_st("confirm3", 1, 1'b0);
    send(8'h55);
    chk_st("confirm_fail", 0, 1'b0);
    chk("confirm_fail_slip_cnt", 32'(rx.slip_cnt), 1);

    // en dropped in SYNC together with a strobe.
    for (int i = 0; i < 4; i++) send(BC);
    chk_st("resync", 2, 1'b1);
    @(negedge clk_4f);
    en          = 1'b0;
    rx.byte_in  = 8'h33;
    rx.byte_stb = 1'b1;
    push(K_LOST, 8'h00);
    @(negedge clk_4f);
    rx.byte_stb = 1'b0;
    chk_st("en_drop", 0, 1'b0);
    chk("en_drop_slip_cnt", 32'(rx.slip_cnt), 1);
    chk("en_drop_valid", 32'(rx.valid_out), 0);
    chk("en_drop_bit_slip", 32'(rx.bit_slip), 0);
    en = 1'b1;

    // Async reset mid-SYNC cancels an in-flight valid_out.
    for (int i = 0; i < 4; i++) send(BC);
    chk_st("resync2", 2, 1'b1);
    @(negedge clk_4f);
    rx.byte_in  = 8'h77;
    rx.byte_stb = 1'b1;
    @(posedge clk_4f);
    #1;
    chk("inflight_valid", 32'(rx.valid_out), 1);
    reset_L     = 1'b0;
    rx.byte_stb = 1'b0;
    #1;
    chk_st("mid_reset", 0, 1'b0);
    chk("mid_reset_valid", 32'(rx.valid_out), 0);
    chk("mid_reset_slip_cnt", 32'(rx.slip_cnt), 0);
    chk("mid_reset_data", 32'(rx.data_out), 0);
    chk("mid_reset_sync_lost", 32'(rx.sync_lost), 0);
    @(negedge clk_4f);
    reset_L = 1'b1;
    repeat (2) @(negedge clk_4f);

    chk("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
